// File: rtl/rur_sched_if.sv
// Bundle of the requester descriptor handshake, the RUR command port and the
// completion/status signals shared by rur_sched and its environment.
interface rur_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]     req_vld;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ*100-1:0] req_cmd;
    logic                cru_hold;
    logic [96:0]         cru_rur;
    logic                busy;
    logic                done_vld;
    logic [IDW-1:0]      done_id;

    modport slave (
        input  req_vld, req_cmd, cru_hold,
        output req_rdy, cru_rur, busy, done_vld, done_id
    );

    modport master (
        output req_vld, req_cmd, cru_hold,
        input  req_rdy, cru_rur, busy, done_vld, done_id
    );
endinterface

// File: rtl/rur_sched.sv
// Round-robin scheduler: grants one requester's burst descriptor at a time and
// expands it into consecutive cru_rur beats, then pulses done with the owner.
module rur_sched #(
    parameter int NREQ = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rur_sched_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic [7:0]      r_addr_cur;
    logic [3:0]      r_remain;
    logic [4:0]      r_smc_id;
    logic [2:0]      r_ur_id;
    logic [79:0]     r_lanes;
    logic [96:0]     r_cru_rur;
    logic            r_done_vld;
    logic [IDW-1:0]  r_done_id;

    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_idx;
    logic [NREQ-1:0] w_req_rdy;
    logic            w_hs;
    logic [99:0]     w_cmd;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req_vld[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_cmd = 100'(bus.req_cmd >> (int'(w_grant) * 100));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, grant and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = '0;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_req_rdy[w_grant] = 1'b1;
                    w_hs               = 1'b1;
                    w_state_nxt        = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!bus.cru_hold && (r_remain == 4'd0)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Descriptor latch, beat generation and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_addr_cur <= 8'd0;
            r_remain   <= 4'd0;
            r_smc_id   <= 5'd0;
            r_ur_id    <= 3'd0;
            r_lanes    <= 80'd0;
            r_cru_rur  <= 97'd0;
            r_done_vld <= 1'b0;
            r_done_id  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cru_rur  <= 97'd0;
                    r_done_vld <= 1'b0;
                    if (w_hs) begin
                        r_owner    <= w_grant;
                        r_smc_id   <= w_cmd[99:95];
                        r_ur_id    <= w_cmd[94:92];
                        r_addr_cur <= w_cmd[91:84];
                        r_remain   <= w_cmd[83:80];
                        r_lanes    <= w_cmd[79:0];
                        r_rr_ptr   <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
                    end else begin
                        r_rr_ptr <= r_rr_ptr;
                    end
                end
                ST_ISSUE: begin
                    r_done_vld <= 1'b0;
                    if (!bus.cru_hold) begin
                        r_cru_rur  <= {1'b1, r_smc_id, r_ur_id, r_addr_cur, r_lanes};
                        r_addr_cur <= r_addr_cur + 8'd1;
                        r_remain   <= r_remain - 4'd1;
                    end else begin
                        r_cru_rur <= 97'd0;
                    end
                end
                ST_DRAIN: begin
                    r_cru_rur  <= 97'd0;
                    r_done_vld <= 1'b1;
                    r_done_id  <= r_owner;
                end
                default: begin
                    r_cru_rur  <= 97'd0;
                    r_done_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy  = w_req_rdy;
    assign bus.cru_rur  = r_cru_rur;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done_vld = r_done_vld;
    assign bus.done_id  = r_done_id;
endmodule

// File: doc/rur_sched.md
# rur_sched

Round-robin command scheduler that shares one RUR gather-read port among `NREQ` requesters. Each requester hands over one burst descriptor through a valid/ready handshake. The block expands the burst into consecutive 97-bit `cru_rur` beats on incrementing UR addresses and pauses on upstream hold. One cycle after the last beat, when the RUR accumulator has absorbed it, the block returns a completion pulse tagged with the owner.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_vld`  in  NREQ: per-requester descriptor valid.
- `req_rdy`  out  NREQ: per-requester grant; at most one bit high.
- `req_cmd`  in  NREQ*100: descriptor of requester i at `[i*100 +: 100]`:
  - `smc_id` [99:95]
  - `ur_id` [94:92]
  - `ur_addr` [91:84]
  - `beats_m1` [83:80]
  - `lanes` [79:0]: 16 × {4b byte sel, 1b vld}, same packing as `cru_rur[79:0]`.
- `cru_hold`  in  1: when 1, no beat may be issued this cycle.
- `cru_rur`  out  97: registered command, `{vld, smc_id, ur_id, ur_addr, lanes}`.
- `busy`  out  1: state ≠ IDLE.
- `done_vld`  out  1: one-cycle completion pulse, registered.
- `done_id`  out  $clog2(NREQ): owner of the completed burst; holds its value between pulses.

## Operation
- **State machine:** IDLE → ISSUE → DRAIN → IDLE.
- **IDLE**
  - Combinational round-robin select `g`: first i with `req_vld[i]=1`, searching from `rr_ptr` upward modulo NREQ.
  - `req_rdy[g]=1`; all other `req_rdy` bits are 0.
  - On handshake (`req_vld[g] & req_rdy[g]`), latch the descriptor, `owner=g`, `addr_cur=ur_addr`, `remain=beats_m1`, and `rr_ptr=(g+1) mod NREQ`. Go to ISSUE.
  - If no `req_vld` bit is set, stay in IDLE; `rr_ptr` is unchanged.
- **ISSUE**
  - `req_rdy` is all 0.
  - Each edge with `cru_hold=0`: `cru_rur <= {1, smc_id, ur_id, addr_cur, lanes}`, then `addr_cur <= addr_cur+1` and `remain <= remain-1`.
  - If `remain==0` at that edge, go to DRAIN.
  - Each edge with `cru_hold=1`: `cru_rur[96] <= 0` (other bits don't-care, driven 0), no advance.
- **Address arithmetic:** `addr_cur` is 8-bit and wraps 255→0. `ur_id`, `smc_id` and `lanes` are constant for the whole burst.
- **DRAIN**
  - One cycle, independent of `cru_hold`.
  - At its edge: `cru_rur <= 0`, `done_vld <= 1`, `done_id <= owner`. Go to IDLE.
- **Elsewhere:** `done_vld` is 0 in every other cycle. `cru_rur[96]` is 0 in every cycle not produced by an issuing ISSUE edge.
- **Passthrough:** Descriptor contents are not checked. Bursts with zero lane-valid bits or a foreign `smc_id` are issued normally.
- **Requester changes:** A requester may deassert `req_vld` before it is granted. Fields presented while `req_rdy` is low are ignored.
- **Reset**, asynchronous, immediate:
  - `cru_rur=0`, `done_vld=0`, `done_id=0`, `busy=0`.
  - state=IDLE, `rr_ptr=0`, `addr_cur=0`, `remain=0`.
  - A burst in flight is abandoned with no completion pulse.

## Timing
- **Handshake:** at edge E0 (IDLE).
- **Beats:** with no hold, beat k (k=0..N−1, N=`beats_m1`+1) is visible on `cru_rur` after edge E(k+1).
- **Completion:**
  - The RUR samples the last beat at E(N+1), so its `dr_rur_d` updates after E(N+1).
  - `done_vld` is high in that same cycle.
  - The state is IDLE after E(N+1); the earliest next handshake is at E(N+2).
- **Hold:** every edge spent with `cru_hold=1` in ISSUE adds exactly one cycle to the beats and to `done_vld`.
- **Occupancy:** minimum N+2 cycles per burst, including the grant cycle.
- **Back-to-back:** `cru_rur[96]` is low for exactly two cycles between bursts (DRAIN output cycle plus grant cycle).

## Test plan
- **Single beat:** req 0, `ur_id`=2, `ur_addr`=0x10, `beats_m1`=0.
  - Beat with vld=1, addr 0x10 after E1.
  - `cru_rur[96]`=0 after E2.
  - `done_vld`=1, `done_id`=0 after E2.
  - `req_rdy` low until E3.
- **Address wrap:** req 1, `ur_addr`=0xFE, `beats_m1`=2 → beat addresses 0xFE, 0xFF, 0x00 on consecutive cycles, `ur_id` and `lanes` unchanged; `done_id`=1.
- **Round-robin:** all 4 `req_vld` held high, `beats_m1`=0 → grant order 0,1,2,3,0; `req_rdy` is one-hot or zero every cycle.
- **Hold mid-burst:** `beats_m1`=3, `cru_hold`=1 for 2 cycles after beat 1 → two vld=0 cycles between beats 1 and 2, no addresses skipped, `done_vld` 2 cycles later than the no-hold case.
- **Reset mid-burst:** `rst_n` low after beat 2 of 8 → `cru_rur`, `done_vld`, `busy` are 0 immediately; no `done_vld` after release; next grant goes to the lowest-index valid requester.
- **Pre-grant change:** req 2 drops `req_vld` while req 0's burst runs, and req 3 is valid → req 3 is granted next; req 2's stale fields are never issued.
